// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with selectable overlap handling and Moore/Mealy
// match output, plus a saturating match counter.
module pattern_detector #(
  parameter int unsigned                PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0]   PATTERN       = 4'b0110,
  parameter int unsigned                OVERLAP       = 1,
  parameter int unsigned                MEALY         = 0,
  parameter int unsigned                COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   a,
  output logic                   y,
  output logic [COUNT_WIDTH-1:0] match_count
);

  localparam int unsigned FILL_W = $clog2(PATTERN_WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_WIDTH);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PATTERN_WIDTH - 1);

  logic [PATTERN_WIDTH-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     y_q, y_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PATTERN_WIDTH-1:0] window;
  logic                     match;

  // The window includes the bit arriving this cycle, so a match is seen one
  // sample before it lands in the history register.
  assign window = {hist_q[PATTERN_WIDTH-2:0], a};
  assign match  = enable && !clear && (fill_q >= FILL_THR) && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      y_d    = 1'b0;
      cnt_d  = '0;
    end else if (enable) begin
      hist_d = window;
      y_d    = match;
      if (match && (OVERLAP == 0)) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
      if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y           = (MEALY != 0) ? (match && reset_n) : y_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench: four detector variants share one stimulus stream and are
// compared against a queue-based reference model through a scoreboard.
module tb_pattern_detector;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       a = 1'b0;

  logic       y_ov, y_no, y_me, y_sat;
  logic [7:0] cnt_ov, cnt_no, cnt_me;
  logic [1:0] cnt_sat;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b0110), .OVERLAP(1), .MEALY(0), .COUNT_WIDTH(8))
    u_moore_ov (.clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
                .y(y_ov), .match_count(cnt_ov));
  pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b0110), .OVERLAP(0), .MEALY(0), .COUNT_WIDTH(8))
    u_moore_no (.clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
                .y(y_no), .match_count(cnt_no));
  pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b0110), .OVERLAP(1), .MEALY(1), .COUNT_WIDTH(8))
    u_mealy    (.clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
                .y(y_me), .match_count(cnt_me));
  pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b0110), .OVERLAP(1), .MEALY(0), .COUNT_WIDTH(2))
    u_sat      (.clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
                .y(y_sat), .match_count(cnt_sat));

  typedef struct {
    bit y_ov;
    int cnt_ov;
    bit y_no;
    int cnt_no;
    bit y_sat;
    int cnt_sat;
    int cnt_me;
  } exp_t;

  exp_t sb[$];

  // Reference model: sampled bits kept as queues, most recent at the back.
  bit hq_ov[$];
  bit hq_no[$];
  bit m_y_ov, m_y_no, m_y_sat;
  int m_cnt_ov, m_cnt_no, m_cnt_sat, m_cnt_me;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match(input bit h[$], input bit b);
    logic [3:0] pat;
    logic [3:0] w;
    pat = 4'b0110;
    if (h.size() < 3) return 1'b0;
    w = {h[h.size()-3], h[h.size()-2], h[h.size()-1], b};
    return w == pat;
  endfunction

  task automatic model_reset();
    hq_ov.delete();
    hq_no.delete();
    m_y_ov = 0; m_y_no = 0; m_y_sat = 0;
    m_cnt_ov = 0; m_cnt_no = 0; m_cnt_sat = 0; m_cnt_me = 0;
  endtask

  task automatic step(input bit en, input bit clr, input bit bit_in);
    bit   m_ov, m_no;
    exp_t e;
    exp_t got;
    @(negedge clock);
    enable = en;
    clear  = clr;
    a      = bit_in;
    m_ov = en && !clr && model_match(hq_ov, bit_in);
    m_no = en && !clr && model_match(hq_no, bit_in);
    #1;
    check("mealy_y", {31'd0, y_me}, {31'd0, m_ov});
    if (clr) begin
      model_reset();
    end else if (en) begin
      hq_ov.push_back(bit_in);
      if (hq_ov.size() > 3) void'(hq_ov.pop_front());
      if (m_no) hq_no.delete();
      else begin
        hq_no.push_back(bit_in);
        if (hq_no.size() > 3) void'(hq_no.pop_front());
      end
      m_y_ov = m_ov; m_y_sat = m_ov; m_y_no = m_no;
      if (m_ov) begin
        m_cnt_ov++;
        m_cnt_me++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      if (m_no) m_cnt_no++;
    end
    e.y_ov = m_y_ov; e.cnt_ov = m_cnt_ov;
    e.y_no = m_y_no; e.cnt_no = m_cnt_no;
    e.y_sat = m_y_sat; e.cnt_sat = m_cnt_sat;
    e.cnt_me = m_cnt_me;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    check("ov_y",    {31'd0, y_ov},   {31'd0, got.y_ov});
    check("ov_cnt",  {24'd0, cnt_ov}, got.cnt_ov);
    check("no_y",    {31'd0, y_no},   {31'd0, got.y_no});
    check("no_cnt",  {24'd0, cnt_no}, got.cnt_no);
    check("sat_y",   {31'd0, y_sat},  {31'd0, got.y_sat});
    check("sat_cnt", {30'd0, cnt_sat}, got.cnt_sat);
    check("me_cnt",  {24'd0, cnt_me}, got.cnt_me);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_y_ov"},  {31'd0, y_ov},  0);
    check({tag, "_y_no"},  {31'd0, y_no},  0);
    check({tag, "_y_me"},  {31'd0, y_me},  0);
    check({tag, "_y_sat"}, {31'd0, y_sat}, 0);
    check({tag, "_cnt_ov"},  {24'd0, cnt_ov},  0);
    check({tag, "_cnt_no"},  {24'd0, cnt_no},  0);
    check({tag, "_cnt_me"},  {24'd0, cnt_me},  0);
    check({tag, "_cnt_sat"}, {30'd0, cnt_sat}, 0);
  endtask

  // Reset is asserted mid-cycle, so the outputs must clear before any edge.
  task automatic pulse_reset();
    @(negedge clock);
    enable  = 1'b1;
    clear   = 1'b0;
    a       = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b0;
    model_reset();
    #1;
    check_zero("rst_release");
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b0, v[i]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_zero("reset");

    // Overlapping stream: two Moore/Mealy matches, one non-overlap match.
    feed(32'b0110110, 7);

    // Enable gating: the gated '1' must not reach the history.
    pulse_reset();
    feed(32'b011, 3);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Counter saturation on the 2-bit instance.
    pulse_reset();
    for (int r = 0; r < 5; r++) feed(32'b0110, 4);

    // Reset mid-pattern, then clear mid-pattern.
    pulse_reset();
    feed(32'b011, 3);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0);
    feed(32'b011, 3);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Random traffic with sparse clears and enable drops.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 4) != 0), ($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
    end

    if (sb.size() != 0) check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The module SHALL have parameter PATTERN_WIDTH, default 4, giving the pattern length N in bits (legal range 2..16).
REQ-002 The module SHALL have parameter PATTERN, default 4'b0110, giving the pattern; the MSB is the oldest bit, the LSB is the newest bit.
REQ-003 The module SHALL have parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 The module SHALL have parameter MEALY, default 0: 0 = Moore (registered) output, 1 = Mealy (combinational) output.
REQ-005 The module SHALL have parameter COUNT_WIDTH, default 8, giving the width of the match counter.
REQ-006 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The module SHALL have port enable, input, 1 bit: sample strobe; a is sampled only in cycles where enable=1.
REQ-009 The module SHALL have port clear, input, 1 bit: synchronous clear of all state.
REQ-010 The module SHALL have port a, input, 1 bit: serial data bit.
REQ-011 The module SHALL have port y, output, 1 bit: match indication.
REQ-012 The module SHALL have port match_count, output, COUNT_WIDTH bits: number of matches since reset or clear.

Function
REQ-013 An internal N-bit history register SHALL shift left on each enabled sample, with a entering the LSB; it SHALL hold when enable=0.
REQ-014 An internal fill counter SHALL count enabled samples, saturating at N; the history SHALL be considered valid only when fill counts the current sample as the Nth or later.
REQ-015 A match event SHALL occur in a cycle where enable=1, fill >= N-1, and {history[N-2:0], a} == PATTERN.
REQ-016 With OVERLAP=1, fill SHALL be unaffected by a match; with OVERLAP=0, fill SHALL be set to 0 on the edge following a match, so the next match needs N fresh samples.
REQ-017 With MEALY=0, y SHALL be a register set to 1 on the edge after a match event.
REQ-018 With MEALY=0, y SHALL be loaded with 0 on any later enabled sample without a match, and SHALL hold its value while enable=0.
REQ-019 With MEALY=1, y SHALL equal the match event combinationally, with zero latency and high only in the matching cycle.
REQ-020 match_count SHALL increment by 1 on the edge after each match event and SHALL saturate at all-ones, never wrapping.
REQ-021 clear=1 SHALL, on the next edge, zero the history, fill, Moore y register and match_count; clear SHALL take priority over enable, and the sample in that cycle SHALL be discarded.
REQ-022 With MEALY=1, y SHALL be forced to 0 while clear=1.
REQ-023 The Moore and Mealy outputs SHALL use the same match event, and the Moore y SHALL lag the Mealy y by exactly one clock.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for a clock edge, set history=0, fill=0, the Moore y register=0 and match_count=0.
REQ-025 While reset_n=0 with MEALY=1, y SHALL be 0.
REQ-026 Reset asserted mid-pattern SHALL discard all partial progress; after release, detection SHALL restart from an empty history.

Verification (N=4, PATTERN=0110, enable=1 every cycle unless stated)
REQ-027 Scenario 1 SHALL check reset: reset_n=0, then release -> y=0 and match_count=0 before any sample.
REQ-028 Scenario 2 SHALL check Moore overlap: MEALY=0, OVERLAP=1, stream 0,1,1,0,1,1,0 -> y=1 in the cycle after the 4th and after the 7th sample, and match_count=2.
REQ-029 Scenario 3 SHALL check non-overlap: OVERLAP=0, same stream -> a single y pulse after the 4th sample, and match_count=1.
REQ-030 Scenario 4 SHALL check the Mealy output and enable gating: MEALY=1, stream 0,1,1 then a=0 with enable=0 -> y=0; then enable=1 -> y=1 in that same cycle; bits presented with enable=0 SHALL not alter the history.
REQ-031 Scenario 5 SHALL check counter saturation: COUNT_WIDTH=2, stream 0110 repeated 5 times -> match_count steps 1,2,3 and then stays at 3.
REQ-032 Scenario 6 SHALL check reset and clear mid-pattern: feed 0,1,1, pulse reset_n low, then feed 0 -> no match and match_count=0; repeat with clear=1 for one cycle instead of reset -> same result.
